// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op-code encodings, FSM state type and the
// flag values reported for undefined op codes.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_LUI  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic overflow;
        logic carryout;
    } flags_t;

    // Undefined ops yield result 0; zero follows from the result.
    localparam flags_t UNDEF_FLAGS = '{overflow: 1'b0, carryout: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: start latches a/b, then DATA_W iterations.
// done is asserted combinationally during the final iteration with its product.
module alu_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q & (cnt_q == '0);
    assign product  = acc_next;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '1;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
            cnt_d    = cnt_q - 1'b1;
            busy_d   = (cnt_q != '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and held result under back-pressure.
// Define ALU_SEQ_MUL_EN to build the iterative multiply (op 12) and MUL_BUSY state.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              carryout,
    output logic              zero
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int HALF_W  = DATA_W / 2;
    localparam int MSB     = DATA_W - 1;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              carryout_q, carryout_d;
    logic              zero_q, zero_d;

    logic              accept;
    logic              load_alu;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   diff_w;
    logic [DATA_W-1:0] alu_res;
    flags_t            alu_flags;

    assign in_ready = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign shamt    = a[SHAMT_W-1:0];
    assign sum_w    = {1'b0, a} + {1'b0, b};
    assign diff_w   = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res   = '0;
        alu_flags = UNDEF_FLAGS;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD: begin
                alu_res            = sum_w[MSB:0];
                alu_flags.carryout = sum_w[DATA_W];
                alu_flags.overflow = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
            end
            OP_LUI:  alu_res = {b[HALF_W-1:0], {HALF_W{1'b0}}};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, diff_w[DATA_W]};
            OP_SLL:  alu_res = b << shamt;
            OP_SUB: begin
                alu_res            = diff_w[MSB:0];
                alu_flags.carryout = diff_w[DATA_W];
                alu_flags.overflow = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
            end
            // Differing signs decide directly; equal signs reduce to the borrow.
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                (a[MSB] != b[MSB]) ? a[MSB] : diff_w[DATA_W]};
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = DATA_W'($signed(b) >>> shamt);
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic              is_mul;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign is_mul = (op == OP_MUL);

    alu_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .resetn  (resetn),
        .start   (accept & is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~out_ready;
        result_d    = result_q;
        overflow_d  = overflow_q;
        carryout_d  = carryout_q;
        zero_d      = zero_q;
        load_alu    = accept;
`ifdef ALU_SEQ_MUL_EN
        if (accept && is_mul) begin
            load_alu = 1'b0;
            state_d  = ST_MUL_BUSY;
        end
        if ((state_q == ST_MUL_BUSY) && mul_done) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            result_d    = mul_product;
            overflow_d  = 1'b0;
            carryout_d  = 1'b0;
            zero_d      = (mul_product == '0);
        end
`endif
        if (load_alu) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            overflow_d  = alu_flags.overflow;
            carryout_d  = alu_flags.carryout;
            zero_d      = (alu_res == '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            carryout_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            carryout_q  <= carryout_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign carryout  = carryout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a scoreboard of expected results; follows
// ALU_SEQ_MUL_EN to select the multiply or undefined-op expectations.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        cout;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        carryout;
    logic        zero;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    exp_t mon_e;

    alu_seq #(
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .carryout  (carryout),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t            e;
        longint          sx, sy, ss;
        longint unsigned ux, uy, us;
        int              sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        sh = int'(x[4:0]);
        e.res = 32'd0; e.ovf = 1'b0; e.cout = 1'b0;
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: begin
                us = ux + uy; e.res = us[31:0]; e.cout = us[32];
                ss = sx + sy; e.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd3: e.res = {y[15:0], 16'h0000};
            4'd4: e.res = (x < y) ? 32'd1 : 32'd0;
            4'd5: e.res = y << sh;
            4'd6: begin
                us = ux - uy; e.res = us[31:0]; e.cout = (x < y);
                ss = sx - sy; e.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd7: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8: e.res = x ^ y;
            4'd9: e.res = ~(x | y);
            4'd10: e.res = y >> sh;
            4'd11: e.res = 32'($signed(y) >>> sh);
`ifdef ALU_SEQ_MUL_EN
            4'd12: begin us = ux * uy; e.res = us[31:0]; end
`endif
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Presents an op and waits for acceptance; in_valid is left high.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        sb.push_back(model(o, x, y));
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            chk("sb_pending", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_result",   result,   mon_e.res);
                chk("sb_overflow", overflow, mon_e.ovf);
                chk("sb_carryout", carryout, mon_e.cout);
                chk("sb_zero",     zero,     mon_e.zero);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, k;
        logic ok;
        resetn = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result",    result,    0);
        chk("rst_overflow",  overflow,  0);
        chk("rst_carryout",  carryout,  0);
        chk("rst_zero",      zero,      0);
        chk("rst_in_ready",  in_ready,  1);
        resetn = 1'b1;
        tick();

        send(OP_ADD, 32'h7FFFFFFF, 32'h1); in_valid = 1'b0;
        chk("add_latency",  out_valid, 1);
        chk("add_result",   result,    32'h80000000);
        chk("add_overflow", overflow,  1);
        chk("add_carryout", carryout,  0);
        chk("add_zero",     zero,      0);

        send(OP_SUB, 32'd5, 32'd5); in_valid = 1'b0;
        chk("sub_eq_result", result, 0);
        chk("sub_eq_zero",   zero,   1);
        send(OP_SUB, 32'd0, 32'd1); in_valid = 1'b0;
        chk("sub_bor_result",   result,   32'hFFFFFFFF);
        chk("sub_bor_carryout", carryout, 1);
        chk("sub_bor_overflow", overflow, 0);
        send(OP_SLT, 32'h80000000, 32'd1); in_valid = 1'b0;
        chk("slt_result", result, 1);
        send(OP_SLTU, 32'h80000000, 32'd1); in_valid = 1'b0;
        chk("sltu_result", result, 0);
        send(OP_SRA, 32'd4, 32'h80000000); in_valid = 1'b0;
        chk("sra_result", result, 32'hF8000000);
        send(4'd14, 32'h1234, 32'h5678); in_valid = 1'b0;
        chk("undef_result", result, 0);
        chk("undef_zero",   zero,   1);

        // Back-to-back mixed stream checked by the scoreboard.
        send(OP_XOR, 32'hA5A5F00F, 32'h0FF0FFFF);
        t0 = cyc;
        send(OP_NOR, 32'h0000FFFF, 32'h00FF0000);
        send(OP_SRL, 32'hFFFFFFE3, 32'h80000010);
        send(OP_SLL, 32'hFFFFFF1F, 32'h00000003);
        t1 = cyc;
        chk("stream_tput", t1 - t0, 3);
        send(OP_LUI, 32'h0, 32'hDEAD_BEEF);
        send(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
        send(OP_OR, 32'h0, 32'h0);
        send(OP_ADD, 32'hFFFFFFFF, 32'h1);
        send(OP_SUB, 32'h80000000, 32'h1);
        send(4'd13, 32'h1, 32'h1);
        send(4'd15, 32'h1, 32'h1);
        in_valid = 1'b0;
        tick();

        // Back-pressure: hold the result for three cycles with a pending op.
        out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd2);
        op = OP_OR; a = 32'hF0; b = 32'h0F;
        repeat (3) begin
            @(negedge clk);
            chk("bp_result",    result,    3);
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(OP_OR, 32'hF0, 32'h0F);
        t0 = cyc;
        chk("bp_same_edge", result, 32'hFF);
        send(OP_XOR, 32'h1, 32'h3);
        send(OP_SLTU, 32'h1, 32'h2);
        send(OP_SRA, 32'h1, 32'h7FFFFFFE);
        t1 = cyc;
        in_valid = 1'b0;
        chk("bp_tput", t1 - t0, 3);
        tick();

`ifdef ALU_SEQ_MUL_EN
        send(OP_MUL, 32'h00010000, 32'h00010001); in_valid = 1'b0;
        k = 0; ok = 1'b1;
        while (!out_valid && k < 100) begin
            if (in_ready !== 1'b0) ok = 1'b0;
            tick();
            k++;
        end
        chk("mul_latency",  k, 32);
        chk("mul_in_ready", ok, 1);
        chk("mul_result",   result, 32'h00010000);
        send(OP_MUL, 32'hDEADBEEF, 32'h12345678); in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin tick(); k++; end
        chk("mul2_latency", k, 32);
        tick();
        send(OP_MUL, 32'd3, 32'd5); in_valid = 1'b0;
        repeat (10) tick();
`else
        send(OP_MUL, 32'h00010000, 32'h00010001); in_valid = 1'b0;
        chk("mul_off_latency", out_valid, 1);
        chk("mul_off_result",  result,    0);
        chk("mul_off_zero",    zero,      1);
        tick();
        out_ready = 1'b0;
        send(OP_ADD, 32'd9, 32'd9); in_valid = 1'b0;
        repeat (2) tick();
`endif
        resetn = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready",  in_ready,  1);
        chk("mid_rst_result",    result,    0);
        sb.delete();
        out_ready = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        ok = 1'b1;
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("no_stale_result", ok, 1);
        send(OP_ADD, 32'd2, 32'd3); in_valid = 1'b0;
        chk("post_rst_add", result, 5);
        repeat (2) tick();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
